v3_filter_ctrl: RTL and testbench

Sequencer and event extractor for the v3 trapezoidal shaping filter. It drives the filter's active-low reset through flush and warm-up, then watches the filter output for threshold crossings. For each pulse it captures peak amplitude, width and timestamp, and presents them on a valid/ready event port. A dead-time window follows each accepted event, and the block counts pulses lost to back-pressure or dead time.

---
 rtl/v3_filter_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_v3_filter_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v3_filter_ctrl.sv
// v3_filter_ctrl: sequencer and pulse event extractor for the v3 trapezoidal filter.
// The block flushes the filter, waits for its pipeline to fill, then measures each
// threshold crossing. For every pulse it reports peak, width and start time on a
// valid/ready port, applies a dead time, and counts pulses it had to discard.
module v3_filter_ctrl #(
  parameter int SIZE_ADC_DATA = 14,
  parameter int FLUSH_CYCLES  = 4,
  parameter int FILL_CYCLES   = 16,
  parameter int DEAD_CYCLES   = 8,
  parameter int THR_DEFAULT   = 100
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic signed [SIZE_ADC_DATA-1:0] flt_data,
  output logic                            flt_reset_n,
  input  logic                            cfg_we,
  input  logic signed [SIZE_ADC_DATA-1:0] cfg_threshold,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic signed [SIZE_ADC_DATA-1:0] evt_amp,
  output logic [7:0]                      evt_width,
  output logic [15:0]                     evt_time,
  output logic [15:0]                     evt_lost,
  output logic                            busy
);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_WARMUP,
    S_ARMED,
    S_PULSE,
    S_REPORT,
    S_DEAD
  } state_t;

  // One shared counter serves flush, fill and dead-time phases, so it is sized
  // for the longest of the three.
  localparam int CNT_MAX_FF = (FLUSH_CYCLES > FILL_CYCLES) ? FLUSH_CYCLES : FILL_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_FF > DEAD_CYCLES) ? CNT_MAX_FF : DEAD_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 2);

  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);

  state_t                            state;
  logic [CNT_W-1:0]                  cnt;
  logic [15:0]                       timestamp;
  logic signed [SIZE_ADC_DATA-1:0]   threshold;
  logic                              above_d;
  logic signed [SIZE_ADC_DATA-1:0]   peak;
  logic [7:0]                        width;
  logic [15:0]                       pulse_time;

  logic above;
  logic rising;

  // Strict signed compare against the live threshold; only a fresh rising edge
  // may start a pulse, so a signal already high on arming never triggers.
  assign above  = flt_data > threshold;
  assign rising = above & ~above_d;

  // Whole controller: free-running timestamp, threshold register, sequencing FSM,
  // pulse measurement, event port and lost-pulse counter, all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FLUSH;
      cnt         <= '0;
      timestamp   <= '0;
      threshold   <= SIZE_ADC_DATA'(THR_DEFAULT);
      above_d     <= 1'b0;
      peak        <= '0;
      width       <= '0;
      pulse_time  <= '0;
      flt_reset_n <= 1'b0;
      evt_valid   <= 1'b0;
      evt_amp     <= '0;
      evt_width   <= '0;
      evt_time    <= '0;
      evt_lost    <= '0;
      busy        <= 1'b1;
    end else begin
      timestamp <= timestamp + 16'd1;
      above_d   <= above;
      if (cfg_we) begin
        threshold <= cfg_threshold;
      end

      if (!enable) begin
        // Dropping enable abandons whatever is in flight without counting it lost.
        state       <= S_FLUSH;
        cnt         <= '0;
        flt_reset_n <= 1'b0;
        evt_valid   <= 1'b0;
        busy        <= 1'b1;
      end else begin
        if ((state == S_REPORT || state == S_DEAD) && rising && evt_lost != 16'hFFFF) begin
          evt_lost <= evt_lost + 16'd1;
        end

        case (state)
          S_FLUSH: begin
            flt_reset_n <= 1'b0;
            busy        <= 1'b1;
            if (cnt == FLUSH_LAST) begin
              state       <= S_WARMUP;
              cnt         <= '0;
              flt_reset_n <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_WARMUP: begin
            if (cnt == FILL_LAST) begin
              state <= S_ARMED;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_ARMED: begin
            if (rising) begin
              state      <= S_PULSE;
              peak       <= flt_data;
              width      <= 8'd1;
              pulse_time <= timestamp;
              busy       <= 1'b1;
            end
          end

          S_PULSE: begin
            if (above) begin
              if (width != 8'hFF) begin
                width <= width + 8'd1;
              end
              if (flt_data > peak) begin
                peak <= flt_data;
              end
            end else begin
              state     <= S_REPORT;
              evt_amp   <= peak;
              evt_width <= width;
              evt_time  <= pulse_time;
              evt_valid <= 1'b1;
            end
          end

          S_REPORT: begin
            if (evt_valid && evt_ready) begin
              evt_valid <= 1'b0;
              state     <= S_DEAD;
              cnt       <= '0;
            end
          end

          S_DEAD: begin
            if (cnt == DEAD_LAST) begin
              state <= S_ARMED;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state       <= S_FLUSH;
            cnt         <= '0;
            flt_reset_n <= 1'b0;
            evt_valid   <= 1'b0;
            busy        <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_v3_filter_ctrl.sv
// Testbench for v3_filter_ctrl: a per-cycle vector table for the basic pulse, hand
// written sequences for back-pressure, signed threshold, enable drop and wrap, and
// a scoreboard queue of expected events popped on every handshake.
module tb_v3_filter_ctrl;

  localparam int W = 14;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b1;
  logic signed [W-1:0] flt_data = '0;
  logic                flt_reset_n;
  logic                cfg_we = 1'b0;
  logic signed [W-1:0] cfg_threshold = '0;
  logic                evt_valid;
  logic                evt_ready = 1'b0;
  logic signed [W-1:0] evt_amp;
  logic [7:0]          evt_width;
  logic [15:0]         evt_time;
  logic [15:0]         evt_lost;
  logic                busy;

  v3_filter_ctrl #(
    .SIZE_ADC_DATA(W),
    .FLUSH_CYCLES(4),
    .FILL_CYCLES(16),
    .DEAD_CYCLES(8),
    .THR_DEFAULT(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .flt_data(flt_data),
    .flt_reset_n(flt_reset_n),
    .cfg_we(cfg_we),
    .cfg_threshold(cfg_threshold),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_amp(evt_amp),
    .evt_width(evt_width),
    .evt_time(evt_time),
    .evt_lost(evt_lost),
    .busy(busy)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Reference cycle counter: number of clock edges since reset release, mod 2^16
  logic [15:0] ts_model;
  always @(posedge clk or posedge reset) begin
    if (reset) ts_model <= 16'd0;
    else       ts_model <= ts_model + 16'd1;
  end

  typedef struct {
    logic signed [W-1:0] amp;
    logic [7:0]          width;
    logic [15:0]         stamp;
  } evt_t;

  evt_t exp_q[$];

  typedef struct {
    int   data;
    logic ready;
    logic exp_valid;
    logic exp_busy;
    logic push_evt;
  } vec_t;

  vec_t tbl[14];

  int tests_run = 0;
  int failures  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int data, input logic ready);
    flt_data  = W'(data);
    evt_ready = ready;
  endtask

  task automatic pushEvent(input int amp, input int width, input logic [15:0] stamp);
    evt_t e;
    e.amp   = W'(amp);
    e.width = 8'(width);
    e.stamp = stamp;
    exp_q.push_back(e);
  endtask

  // Advance one clock; a handshake about to happen on this edge is scored first
  task automatic step();
    if (evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        failures++;
        $display("[TB] FAIL unexpected_event: got event amp %0d time %0h, expected none", evt_amp, evt_time);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        checkOutput("evt_amp", 32'(evt_amp), 32'(e.amp));
        checkOutput("evt_width", 32'(evt_width), 32'(e.width));
        checkOutput("evt_time", 32'(evt_time), 32'(e.stamp));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runArming(input string tag);
    for (int k = 1; k <= 20; k++) begin
      step();
      checkOutput({tag, "_flt_reset_n"}, 32'(flt_reset_n), 32'(k >= 4));
      checkOutput({tag, "_busy"}, 32'(busy), 32'(k < 20));
      checkOutput({tag, "_valid"}, 32'(evt_valid), 0);
    end
  endtask

  task automatic runDead(input string tag);
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput({tag, "_dead_busy"}, 32'(busy), 32'(k < 8));
    end
  endtask

  initial begin
    logic [15:0] stamp3;
    int n;

    // Basic pulse 50,150,300,200,90 with ready high, then dead time
    tbl[0]  = '{50,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{150, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{300, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{200, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{90,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{90,  1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 6; i <= 12; i++) tbl[i] = '{90, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{90,  1'b1, 1'b0, 1'b0, 1'b0};

    // Reset values
    applyStimulus(500, 1'b0);
    @(negedge clk);
    checkOutput("rst_flt_reset_n", 32'(flt_reset_n), 0);
    checkOutput("rst_valid", 32'(evt_valid), 0);
    checkOutput("rst_busy", 32'(busy), 1);
    checkOutput("rst_amp", 32'(evt_amp), 0);
    checkOutput("rst_width", 32'(evt_width), 0);
    checkOutput("rst_time", 32'(evt_time), 0);
    checkOutput("rst_lost", 32'(evt_lost), 0);
    reset = 1'b0;

    // Flush and warm-up with data held above threshold: no trigger afterwards
    runArming("boot");
    repeat (3) begin
      step();
      checkOutput("armed_no_trig_busy", 32'(busy), 0);
      checkOutput("armed_no_trig_valid", 32'(evt_valid), 0);
    end

    // Table-driven basic pulse
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].data, tbl[i].ready);
      if (tbl[i].push_evt) pushEvent(300, 3, ts_model);
      step();
      checkOutput("tbl_valid", 32'(evt_valid), 32'(tbl[i].exp_valid));
      checkOutput("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
    end

    // Back-pressure: held event stays stable, crossings during REPORT are lost
    applyStimulus(0, 1'b0);
    step();
    applyStimulus(200, 1'b0);
    stamp3 = ts_model;
    pushEvent(250, 2, stamp3);
    step();
    checkOutput("bp_busy", 32'(busy), 1);
    applyStimulus(250, 1'b0);
    step();
    applyStimulus(0, 1'b0);
    step();
    checkOutput("bp_valid", 32'(evt_valid), 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i == 3) ? 120 : 0, 1'b0);
      step();
      checkOutput("bp_hold_valid", 32'(evt_valid), 1);
      checkOutput("bp_hold_amp", 32'(evt_amp), 250);
      checkOutput("bp_hold_width", 32'(evt_width), 2);
      checkOutput("bp_hold_time", 32'(evt_time), 32'(stamp3));
    end
    checkOutput("bp_lost_1", 32'(evt_lost), 1);
    // Crossing on the handshake cycle still counts as lost
    applyStimulus(120, 1'b1);
    step();
    checkOutput("bp_hs_valid", 32'(evt_valid), 0);
    checkOutput("bp_lost_2", 32'(evt_lost), 2);
    runDead("bp");
    // Still above on arrival in ARMED: no trigger without a fresh crossing
    repeat (3) begin
      step();
      checkOutput("bp_rearm_busy", 32'(busy), 0);
      checkOutput("bp_rearm_lost", 32'(evt_lost), 2);
    end

    // Negative threshold, signed compare
    applyStimulus(-400, 1'b1);
    cfg_we = 1'b1;
    cfg_threshold = W'(-300);
    step();
    cfg_we = 1'b0;
    step();
    checkOutput("neg_below_busy", 32'(busy), 0);
    applyStimulus(-200, 1'b1);
    pushEvent(-200, 1, ts_model);
    step();
    checkOutput("neg_trig_busy", 32'(busy), 1);
    applyStimulus(-500, 1'b1);
    step();
    checkOutput("neg_valid", 32'(evt_valid), 1);
    step();
    checkOutput("neg_hs_valid", 32'(evt_valid), 0);
    runDead("neg");
    cfg_we = 1'b1;
    cfg_threshold = W'(100);
    step();
    cfg_we = 1'b0;
    applyStimulus(-200, 1'b1);
    step();
    checkOutput("pos_thr_no_trig", 32'(busy), 0);
    applyStimulus(-500, 1'b1);
    step();
    applyStimulus(-200, 1'b1);
    step();
    checkOutput("pos_thr_no_trig2", 32'(busy), 0);

    // Enable dropped mid-pulse: flush, no event, lost unchanged, then re-arm
    applyStimulus(0, 1'b1);
    step();
    applyStimulus(200, 1'b1);
    step();
    checkOutput("en_pulse_busy", 32'(busy), 1);
    enable = 1'b0;
    applyStimulus(250, 1'b1);
    step();
    checkOutput("en_flt_reset_n", 32'(flt_reset_n), 0);
    checkOutput("en_valid", 32'(evt_valid), 0);
    checkOutput("en_busy", 32'(busy), 1);
    checkOutput("en_lost", 32'(evt_lost), 2);
    applyStimulus(0, 1'b1);
    repeat (2) begin
      step();
      checkOutput("en_hold_flt_reset_n", 32'(flt_reset_n), 0);
    end
    enable = 1'b1;
    runArming("reen");
    applyStimulus(200, 1'b1);
    pushEvent(200, 1, ts_model);
    step();
    applyStimulus(0, 1'b1);
    step();
    checkOutput("reen_valid", 32'(evt_valid), 1);
    step();
    runDead("reen");
    checkOutput("reen_lost", 32'(evt_lost), 2);

    // Long pulse across the timestamp wrap: width saturates, time is the start stamp
    applyStimulus(0, 1'b1);
    n = 0;
    while (ts_model != 16'hFFF0 && n < 70000) begin
      step();
      n++;
    end
    checkOutput("wrap_wait_reached", 32'(ts_model == 16'hFFF0), 1);
    applyStimulus(300, 1'b1);
    pushEvent(300, 255, ts_model);
    repeat (400) step();
    applyStimulus(0, 1'b1);
    step();
    checkOutput("sat_valid", 32'(evt_valid), 1);
    checkOutput("sat_width", 32'(evt_width), 255);
    checkOutput("sat_time", 32'(evt_time), 32'hFFF0);
    step();
    runDead("sat");
    applyStimulus(150, 1'b1);
    pushEvent(150, 1, ts_model);
    step();
    applyStimulus(0, 1'b1);
    step();
    checkOutput("post_wrap_valid", 32'(evt_valid), 1);
    step();
    runDead("post_wrap");

    checkOutput("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
